// File: rtl/pmem_responder.sv
// pmem_responder
//   Target side of the 256-bit pmem line interface below the L2 cache.
//   It serves one line read or one line write at a time. Each access
//   completes after a programmable latency. Completion is signalled by a
//   one-cycle pmem_resp pulse. Array contents are not reset.
//
//   Optional build macro: PMEM_RAND_LAT_EN
//     When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11) adds 0..7
//     extra cycles to every access. The sequence is deterministic from
//     LFSR_SEED.
//
//   Ports
//     clk           rising-edge clock
//     rst_n         asynchronous active-low reset
//     pmem_address  byte address; bits [4:0] ignored, upper bits alias
//     pmem_read     line read request, held until pmem_resp or dropped (abort)
//     pmem_write    line write request, held until pmem_resp or dropped (abort)
//     pmem_wdata    write line
//     pmem_rdata    read line, held until the next read completes
//     pmem_resp     one-cycle completion pulse
//     pmem_err      sticky flag: read and write requested together
//
//   state | meaning
//   IDLE  | waiting for a request; accepts and latches on the next edge
//   BUSY  | counting latency; request drop aborts; commit/read at count 0
//   RESP  | pmem_resp high for this single cycle
module pmem_responder #(
  parameter int          DEPTH     = 64,
  parameter int          LATENCY   = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  pmem_address,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         pmem_err
);

  localparam int IW = $clog2(DEPTH);
  // Wide enough for LATENCY-1 plus the random extension of up to 7.
  localparam int CW = 6;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   lat_load;
  logic            op_wr;
  logic [IW-1:0]   idx;
  logic [255:0]    wdata_q;
  logic [255:0]    mem [DEPTH];
  logic            req;
  logic            accept;
  logic            done;
  logic            unused_addr;

  assign req = pmem_read | pmem_write;

  // Only the index bits select a line; the rest alias onto the array.
  assign unused_addr = ^pmem_address;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A dropped request wins over completion, even at count 0.
        if (!req) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          done      = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign pmem_resp = (state == RESP);

`ifdef PMEM_RAND_LAT_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[14:0], lfsr_fb};
  end

  assign lat_load = CW'(LATENCY - 1) + CW'(lfsr[2:0]);
`else
  assign lat_load = CW'(LATENCY - 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      op_wr      <= 1'b0;
      idx        <= '0;
      wdata_q    <= '0;
      pmem_rdata <= '0;
      pmem_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= lat_load;
        // Read and write together is served as a write.
        op_wr   <= pmem_write;
        idx     <= pmem_address[5 +: IW];
        wdata_q <= pmem_wdata;
        if (pmem_read && pmem_write) pmem_err <= 1'b1;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (done && !op_wr) pmem_rdata <= mem[idx];
    end
  end

  // Array storage has no reset. A reset forces IDLE, so done cannot fire
  // and an uncommitted write is simply dropped.
  always_ff @(posedge clk) begin
    if (done && op_wr) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_pmem_responder.sv
module tb_pmem_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  pmem_address = '0;
  logic         pmem_read = 1'b0;
  logic         pmem_write = 1'b0;
  logic [255:0] pmem_wdata = '0;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         pmem_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pmem_responder #(.DEPTH(64), .LATENCY(4), .LFSR_SEED(16'hACE1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .pmem_err     (pmem_err)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents a request at a negedge; lat counts edges after the accept edge
  // until pmem_resp is seen (-1 if it never comes within the budget).
  task automatic access(input logic [15:0] addr, input logic rd, input logic wr,
                        input logic [255:0] wd, output int lat, output logic [255:0] rdat);
    @(negedge clk);
    pmem_address = addr;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_wdata   = wd;
    @(posedge clk);
    // Inputs other than the request strobes must be ignored once accepted.
    #1;
    pmem_address = 16'hFFFF;
    pmem_wdata   = {8{32'h5A5A_A5A5}};
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (pmem_resp) break;
    end
    if (!pmem_resp) lat = -1;
    rdat       = pmem_rdata;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    @(posedge clk);
    #1;
    check("resp_one_cycle", 256'(pmem_resp), 256'(0));
  endtask

  // Request held for the accept edge plus two BUSY edges, then dropped.
  task automatic aborted(input logic [15:0] addr, input logic rd, input logic wr,
                         input logic [255:0] wd);
    logic seen;
    @(negedge clk);
    pmem_address = addr;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_wdata   = wd;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (pmem_resp) seen = 1'b1;
    end
    check("abort_no_resp", 256'(seen), 256'(0));
  endtask

  localparam logic [255:0] LINE_D = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] LINE_A = {8{32'h0123_4567}};
  localparam logic [255:0] LINE_B = {8{32'hB0B0_1111}};
  localparam logic [255:0] LINE_C = {4{64'hC0FF_EE00_1234_5678}};
  localparam logic [255:0] LINE_X = {8{32'h7777_8888}};
  localparam logic [255:0] LINE_E = {8{32'hEEEE_0001}};

  initial begin
    int lat;
    logic [255:0] rd;
    int waited;

    // 1. reset values, basic write then read
    do_reset();
    #1;
    check("rst_resp", 256'(pmem_resp), 256'(0));
    check("rst_rdata", pmem_rdata, '0);
    check("rst_err", 256'(pmem_err), 256'(0));

    access(16'h0040, 1'b0, 1'b1, LINE_D, lat, rd);
    check("wr40_latency", 256'(lat), 256'(4));
    access(16'h0040, 1'b1, 1'b0, '0, lat, rd);
    check("rd40_latency", 256'(lat), 256'(4));
    check("rd40_data", rd, LINE_D);

    // 2. aliasing and ignored low address bits
    access(16'h0020, 1'b0, 1'b1, LINE_A, lat, rd);
    access(16'h0820, 1'b1, 1'b0, '0, lat, rd);
    check("rd820_alias", rd, LINE_A);
    access(16'h003F, 1'b1, 1'b0, '0, lat, rd);
    check("rd3F_lowbits", rd, LINE_A);
    check("rdata_held", pmem_rdata, LINE_A);

    // 3. aborted read, then normal read; aborted write leaves old data
    aborted(16'h0040, 1'b1, 1'b0, '0);
    check("abort_rdata_kept", pmem_rdata, LINE_A);
    access(16'h0040, 1'b1, 1'b0, '0, lat, rd);
    check("after_abort_lat", 256'(lat), 256'(4));
    check("after_abort_data", rd, LINE_D);
    access(16'h0100, 1'b0, 1'b1, LINE_C, lat, rd);
    aborted(16'h0100, 1'b0, 1'b1, LINE_X);
    access(16'h0100, 1'b1, 1'b0, '0, lat, rd);
    check("abort_wr_old_data", rd, LINE_C);

    // 4. read and write together -> write, sticky error
    check("err_before", 256'(pmem_err), 256'(0));
    access(16'h0060, 1'b1, 1'b1, LINE_B, lat, rd);
    check("err_set", 256'(pmem_err), 256'(1));
    check("rw_latency", 256'(lat), 256'(4));
    access(16'h0060, 1'b1, 1'b0, '0, lat, rd);
    check("rw_committed", rd, LINE_B);
    check("err_sticky", 256'(pmem_err), 256'(1));

    // 5a. reset during BUSY on a write: no commit, clean restart
    @(negedge clk);
    pmem_address = 16'h0040;
    pmem_wdata   = LINE_E;
    pmem_write   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_busy_resp", 256'(pmem_resp), 256'(0));
    check("rst_busy_err", 256'(pmem_err), 256'(0));
    check("rst_busy_rdata", pmem_rdata, '0);
    do_reset();
    access(16'h0040, 1'b1, 1'b0, '0, lat, rd);
    check("rst_no_commit", rd, LINE_D);
    check("rst_restart_lat", 256'(lat), 256'(4));

    // 5b. reset while pmem_resp is high drops it without a clock edge
    @(negedge clk);
    pmem_address = 16'h0020;
    pmem_read    = 1'b1;
    waited = 0;
    while (!pmem_resp && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("resp_seen_before_rst", 256'(pmem_resp), 256'(1));
    rst_n = 1'b0;
    #1;
    check("rst_async_resp_drop", 256'(pmem_resp), 256'(0));
    do_reset();

`ifdef PMEM_RAND_LAT_EN
    begin
      int lats [100];
      bit seen_lat [16];
      int distinct;
      bit in_range;
      bit same;
      do_reset();
      in_range = 1'b1;
      for (int i = 0; i < 100; i++) begin
        access(16'h0040, 1'b1, 1'b0, '0, lat, rd);
        lats[i] = lat;
        if (lat < 4 || lat > 11) in_range = 1'b0;
        else seen_lat[lat] = 1'b1;
      end
      distinct = 0;
      for (int i = 0; i < 16; i++) if (seen_lat[i]) distinct++;
      check("rand_lat_range", 256'(in_range), 256'(1));
      check("rand_lat_distinct_ge4", 256'(distinct >= 4), 256'(1));
      do_reset();
      same = 1'b1;
      for (int i = 0; i < 100; i++) begin
        access(16'h0040, 1'b1, 1'b0, '0, lat, rd);
        if (lat != lats[i]) same = 1'b0;
      end
      check("rand_lat_repeat", 256'(same), 256'(1));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
